// File: rtl/seq_div_64by32.sv
// seq_div_64by32: radix-2 restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module seq_div_64by32 #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);
  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [2*N-1:0] d;
  logic [N:0] p, p_sh, p_sub;
  logic [N-1:0] dv;
  logic [CW-1:0] cnt;
  logic dz, ge, accept, zero;
  always_comb begin
    accept = start && state == IDLE;
    zero = divisor == '0;
    p_sh = {p[N-1:0], d[2*N-1]};
    p_sub = p_sh - {1'b0, dv};
    ge = p_sh >= {1'b0, dv};
    state_n = state;
    if (accept) state_n = zero ? DONE : RUN;
    else if (state == RUN && cnt == LAST) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // d holds the dividend shifting out and the quotient shifting in; it ends as the quotient
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d <= '0;
      p <= '0;
      dv <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      dv <= divisor;
      cnt <= '0;
      dz <= zero;
      d <= zero ? '1 : dividend;
      p <= zero ? {1'b0, dividend[N-1:0]} : '0;
    end else if (state == RUN) begin
      d <= {d[2*N-2:0], ge};
      p <= ge ? p_sub : p_sh;
      cnt <= cnt + 1'b1;
    end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign quotient = d;
  assign remainder = p[N-1:0];
  assign div_by_zero = dz;
endmodule

// File: tb/tb_seq_div_64by32.sv
// tb_seq_div_64by32: directed and randomized checks of the sequential 64/32 divider
module tb_seq_div_64by32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [63:0] quotient;
  logic [31:0] remainder;
  int checks = 0, errors = 0;

  seq_div_64by32 #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // lat = number of edges after the accept edge when out_valid is first seen; -1 on timeout
  task automatic run_div(input logic [63:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h dz=%b, need 1 0 0 0 0", in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    run_div(64'd100, 32'd7, lat);
    checks++;
    if (lat !== 64) begin errors++; $display("FAIL basic_latency: got %0d need 64", lat); end
    checks++;
    if (quotient !== 64'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b need 14 2 0", quotient, remainder, div_by_zero);
    end
    ack();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max();
    int lat;
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 64 || quotient !== 64'h0000_0001_0000_0001 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL max: lat=%0d q=%h r=%h dz=%b need 64 0000000100000001 0 0", lat, quotient, remainder, div_by_zero);
    end
    ack();
  endtask

  task automatic test_div_zero();
    int lat;
    run_div(64'h1234_5678_9ABC_DEF0, 32'd0, lat);
    checks++;
    if (lat < 0 || lat > 1) begin errors++; $display("FAIL dz_latency: got %0d need <=1", lat); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || quotient !== '1 || remainder !== 32'h9ABC_DEF0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: v=%b q=%h r=%h dz=%b need 1 ffffffffffffffff 9abcdef0 1", out_valid, quotient, remainder, div_by_zero);
    end
    ack();
  endtask

  task automatic test_edges();
    int lat;
    run_div(64'd0, 32'd5, lat);
    checks++;
    if (lat !== 64 || quotient !== 64'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL zero_dividend: lat=%0d q=%h r=%h need 64 0 0", lat, quotient, remainder);
    end
    ack();
    run_div(64'hDEAD_BEEF_0123_4567, 32'd1, lat);
    checks++;
    if (quotient !== 64'hDEAD_BEEF_0123_4567 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL divisor_one: q=%h r=%h need deadbeef01234567 0", quotient, remainder);
    end
    ack();
    run_div(64'd5, 32'd9, lat);
    checks++;
    if (quotient !== 64'd0 || remainder !== 32'd5) begin
      errors++;
      $display("FAIL small_dividend: q=%0d r=%0d need 0 5", quotient, remainder);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [63:0] q0;
    logic [31:0] r0;
    int cyc;
    @(negedge clk);
    dividend = 64'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_status: in_ready=%b out_valid=%b need 0 0", in_ready, out_valid);
    end
    dividend = 64'd999;
    divisor = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1 || quotient !== 64'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrun_start_ignored: v=%b q=%0d r=%0d dz=%b need 1 14 2 0", out_valid, quotient, remainder, div_by_zero);
    end
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      dividend = 64'd12345 + 64'(i);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q0 || remainder !== r0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b rdy=%b q=%0d r=%0d need 1 0 14 2", i, out_valid, in_ready, quotient, remainder);
      end
    end
    start = 1'b0;
    ack();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    dividend = 64'hFFFF_FFFF_FFFF_FFFF;
    divisor = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b v=%b q=%h r=%h dz=%b need 1 0 0 0 0", in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    run_div(64'd1000, 32'd10, lat);
    checks++;
    if (lat !== 64 || quotient !== 64'd100 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL after_reset: lat=%0d q=%0d r=%0d need 64 100 0", lat, quotient, remainder);
    end
    ack();
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] b;
    logic [95:0] recon;
    int lat;
    for (int i = 0; i < 150; i++) begin
      a = {$urandom, $urandom};
      b = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 8 == 1) a = a >> $urandom_range(0, 63);
      if (b == 0) b = 32'd1;
      run_div(a, b, lat);
      recon = 96'(quotient) * 96'(b) + 96'(remainder);
      checks++;
      if (lat !== 64 || quotient !== a / 64'(b) || remainder !== 32'(a % 64'(b)) || recon !== 96'(a) || remainder >= b) begin
        errors++;
        $display("FAIL random[%0d]: %h/%h lat=%0d q=%h r=%h need q=%h r=%h", i, a, b, lat, quotient, remainder, a / 64'(b), 32'(a % 64'(b)));
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_div_zero();
    test_edges();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
